tex_cache_fill_ctrl: RTL and testbench

- Miss-service stage directly upstream of the dual-port texture cache write port.
- Watches the two cache lookup ports for misses and arbitrates between them.
- Fetches the aligned burst of 64-bit blocks containing the missing word from VRAM through the memory arbiter, and writes each returned block into the cache over its snoop/write port (write, 17-bit block address, 64-bit data).

---
 rtl/tex_cache_fill_ctrl_if.sv | 33 +++
 rtl/tex_cache_fill_ctrl.sv | 126 ++++++++++++
 tb/tb_tex_cache_fill_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tex_cache_fill_ctrl_if.sv
// Miss-service bus bundle: cache lookup misses, memory arbiter burst port,
// cache write port and service status.
interface tex_cache_fill_ctrl_if;
  logic        isMissA;
  logic [18:0] adressLookA;
  logic        isMissB;
  logic [18:0] adressLookB;
  logic        memReq;
  logic [16:0] memAdr;
  logic        memAck;
  logic        memDataValid;
  logic [63:0] memData;
  logic        write;
  logic [16:0] adressOut;
  logic [63:0] dataOut;
  logic        busy;
  logic        servedA;
  logic        servedB;

  modport master (
    input  isMissA, adressLookA, isMissB, adressLookB,
    input  memAck, memDataValid, memData,
    output memReq, memAdr, write, adressOut, dataOut,
    output busy, servedA, servedB
  );

  modport slave (
    output isMissA, adressLookA, isMissB, adressLookB,
    output memAck, memDataValid, memData,
    input  memReq, memAdr, write, adressOut, dataOut,
    input  busy, servedA, servedB
  );
endinterface

// File: rtl/tex_cache_fill_ctrl.sv
// Texture cache miss service: arbitrates two lookup ports, fetches the aligned
// burst holding the missing word and streams each beat into the cache.
module tex_cache_fill_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int HOLDOFF   = 2
) (
  input logic                   i_clk,
  input logic                   i_nrst,
  tex_cache_fill_ctrl_if.master bus
);

  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [16:0]       ALIGN_MASK = ~17'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t              state, stateNext;
  logic                rrPtr;
  logic                coverA, coverB;
  logic                maskA, maskB;
  logic [HOLD_W-1:0]   holdCnt;
  logic [CNT_W-1:0]    beatCnt;
  logic [16:0]         baseAdr;
  logic                write_p1;
  logic [16:0]         adressOut_p1;
  logic [63:0]         dataOut_p1;

  logic        missAEff, missBEff, pickA, pickB;
  logic        beatIn, lastBeat;
  logic [16:0] baseA, baseB, selBase;
  logic        memReq, busy, servedA, servedB;

  assign baseA    = bus.adressLookA[18:2] & ALIGN_MASK;
  assign baseB    = bus.adressLookB[18:2] & ALIGN_MASK;
  assign missAEff = bus.isMissA && !(maskA && (holdCnt != '0));
  assign missBEff = bus.isMissB && !(maskB && (holdCnt != '0));
  assign pickA    = missAEff && (!missBEff || !rrPtr);
  assign pickB    = missBEff && !pickA;
  assign selBase  = pickA ? baseA : baseB;
  assign beatIn   = (state == RECV) && bus.memDataValid;
  assign lastBeat = beatIn && (beatCnt == LAST_BEAT);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    memReq    = 1'b0;
    busy      = 1'b1;
    servedA   = 1'b0;
    servedB   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pickA || pickB) stateNext = REQ;
      end
      REQ: begin
        memReq = 1'b1;
        if (bus.memAck) stateNext = RECV;
      end
      RECV: if (lastBeat) stateNext = DONE;
      DONE: begin
        servedA   = coverA;
        servedB   = coverB;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rrPtr        <= 1'b0;
      coverA       <= 1'b0;
      coverB       <= 1'b0;
      maskA        <= 1'b0;
      maskB        <= 1'b0;
      holdCnt      <= '0;
      beatCnt      <= '0;
      baseAdr      <= '0;
      write_p1     <= 1'b0;
      adressOut_p1 <= '0;
      dataOut_p1   <= '0;
    end else begin
      if (holdCnt != '0) holdCnt <= holdCnt - 1'b1;
      case (state)
        IDLE: if (pickA || pickB) begin
          baseAdr <= selBase;
          // A second port missing in the same burst rides along on this fetch.
          coverA  <= pickA || (missAEff && (baseA == selBase));
          coverB  <= pickB || (missBEff && (baseB == selBase));
          if (missAEff && missBEff) rrPtr <= ~rrPtr;
        end
        REQ:  beatCnt <= '0;
        RECV: if (beatIn) beatCnt <= beatCnt + 1'b1;
        DONE: begin
          holdCnt <= HOLD_LOAD;
          maskA   <= coverA;
          maskB   <= coverB;
        end
        default: ;
      endcase
      // write stage p1: one registered cache write per accepted beat
      write_p1 <= beatIn;
      if (beatIn) begin
        adressOut_p1 <= baseAdr + 17'(beatCnt);
        dataOut_p1   <= bus.memData;
      end
    end
  end

  assign bus.memReq    = memReq;
  assign bus.memAdr    = baseAdr;
  assign bus.busy      = busy;
  assign bus.servedA   = servedA;
  assign bus.servedB   = servedB;
  assign bus.write     = write_p1;
  assign bus.adressOut = adressOut_p1;
  assign bus.dataOut   = dataOut_p1;

endmodule

// File: tb/tb_tex_cache_fill_ctrl.sv
// Randomized scoreboard bench for tex_cache_fill_ctrl: a miss-level model
// predicts requests, the bench plays the memory arbiter, a monitor checks.
module tb_tex_cache_fill_ctrl;
  localparam int BL = 4;
  localparam int HO = 2;

  logic i_clk = 1'b0;
  logic i_nrst = 1'b0;
  tex_cache_fill_ctrl_if bus();

  tex_cache_fill_ctrl #(.BURST_LEN(BL), .HOLDOFF(HO)) dut (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {logic [16:0] adr; logic [63:0] data;} wr_t;
  wr_t         expWrQ[$];
  logic [16:0] expReqQ[$];
  logic [1:0]  expSrvQ[$];

  int total = 0;
  int bad = 0;

  // model state: round-robin preference and the plan for the current scenario
  logic        rrModel = 1'b0;
  int          planN;
  logic [16:0] planBase[2];
  logic [1:0]  planCov[2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [16:0] baseOf(logic [18:0] adr);
    return 17'((int'(adr) / 4) / BL * BL);
  endfunction

  function automatic void predict(logic mA, logic [18:0] aA, logic mB, logic [18:0] aB);
    logic [16:0] bA, bB;
    logic firstB;
    bA = baseOf(aA);
    bB = baseOf(aB);
    if (mA && mB) begin
      firstB  = rrModel;
      rrModel = !rrModel;
      if (bA == bB) begin
        planN = 1; planBase[0] = bA; planCov[0] = 2'b11;
      end else if (!firstB) begin
        planN = 2; planBase[0] = bA; planCov[0] = 2'b10; planBase[1] = bB; planCov[1] = 2'b01;
      end else begin
        planN = 2; planBase[0] = bB; planCov[0] = 2'b01; planBase[1] = bA; planCov[1] = 2'b10;
      end
    end else if (mA) begin
      planN = 1; planBase[0] = bA; planCov[0] = 2'b10;
    end else begin
      planN = 1; planBase[0] = bB; planCov[0] = 2'b01;
    end
    for (int k = 0; k < planN; k++) expReqQ.push_back(planBase[k]);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic setMiss(logic mA, logic [18:0] aA, logic mB, logic [18:0] aB);
    bus.isMissA = mA; bus.adressLookA = aA;
    bus.isMissB = mB; bus.adressLookB = aB;
  endtask

  task automatic checkAllZero(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_memReq"}, bus.memReq, 0);
    chk({tag, "_memAdr"}, bus.memAdr, 0);
    chk({tag, "_write"}, bus.write, 0);
    chk({tag, "_adressOut"}, bus.adressOut, 0);
    chk({tag, "_dataOut"}, bus.dataOut, 0);
    chk({tag, "_served"}, {bus.servedA, bus.servedB}, 0);
  endtask

  // Acts as the memory arbiter for one burst; abortAfter>=0 resets mid-burst.
  task automatic serveBurst(logic [16:0] base, logic [1:0] cov, int abortAfter,
                            logic keepMiss, logic fixedGaps);
    int n;
    int gapTab[4];
    logic [63:0] d;
    gapTab = '{0, 2, 0, 1};
    n = 0;
    while (!bus.memReq && n < 60) begin tick(); n++; end
    if (!bus.memReq) begin
      chk("req_timeout", bus.memReq, 1);
      return;
    end
    repeat ($urandom_range(0, 3)) begin
      bus.memDataValid = 1'($urandom_range(0, 1));
      bus.memData = {$urandom, $urandom};
      tick();
    end
    bus.memDataValid = 1'b0;
    bus.memAck = 1'b1;
    tick();
    bus.memAck = 1'b0;
    for (int i = 0; i < BL; i++) begin
      if (abortAfter == i) begin
        @(posedge i_clk);
        #2;
        i_nrst = 1'b0;
        #1;
        checkAllZero("async_reset");
        setMiss(0, 0, 0, 0);
        rrModel = 1'b0;
        tick();
        i_nrst = 1'b1;
        return;
      end
      repeat (fixedGaps ? gapTab[i % 4] : $urandom_range(0, 2)) tick();
      d = {$urandom, $urandom};
      bus.memData = d;
      bus.memDataValid = 1'b1;
      expWrQ.push_back('{base + 17'(i), d});
      if (i == BL - 1) expSrvQ.push_back(cov);
      tick();
      bus.memDataValid = 1'b0;
    end
    tick();
    if (!keepMiss) begin
      if (cov[1]) bus.isMissA = 1'b0;
      if (cov[0]) bus.isMissB = 1'b0;
    end
    chk("busy_after_done", bus.busy, 0);
  endtask

  task automatic runScenario(logic mA, logic [18:0] aA, logic mB, logic [18:0] aB, logic fixedGaps);
    predict(mA, aA, mB, aB);
    setMiss(mA, aA, mB, aB);
    for (int k = 0; k < planN; k++) serveBurst(planBase[k], planCov[k], -1, 1'b0, fixedGaps);
    repeat (HO + 2) tick();
  endtask

  // monitor: compares every DUT output event against the scoreboard queues
  logic        prevReq = 1'b0;
  logic [16:0] curBase = '0;
  wr_t         w;
  logic [1:0]  s;
  always @(negedge i_clk) begin
    if (i_nrst) begin
      if (bus.memReq && !prevReq) begin
        if (expReqQ.size() == 0) chk("spurious_req", bus.memReq, 0);
        else begin
          curBase = expReqQ.pop_front();
          chk("memAdr", bus.memAdr, curBase);
        end
      end else if (bus.memReq) begin
        chk("memAdr_hold", bus.memAdr, curBase);
      end
      if (bus.write) begin
        if (expWrQ.size() == 0) chk("spurious_write", bus.write, 0);
        else begin
          w = expWrQ.pop_front();
          chk("write_adr", bus.adressOut, w.adr);
          chk("write_data", bus.dataOut, w.data);
        end
      end
      if (bus.servedA || bus.servedB) begin
        if (expSrvQ.size() == 0) chk("spurious_served", {bus.servedA, bus.servedB}, 0);
        else begin
          s = expSrvQ.pop_front();
          chk("served_AB", {bus.servedA, bus.servedB}, s);
        end
      end
    end
    prevReq = bus.memReq;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] aA, aB;
    logic mA, mB;
    int n;
    setMiss(0, 0, 0, 0);
    bus.memAck = 1'b0;
    bus.memDataValid = 1'b0;
    bus.memData = '0;
    repeat (3) tick();
    checkAllZero("reset");
    i_nrst = 1'b1;
    repeat (2) tick();

    runScenario(1, 19'h00125, 0, 19'h0, 1'b0);
    runScenario(1, 19'h00010, 1, 19'h00400, 1'b0);
    runScenario(1, 19'h00010, 1, 19'h00400, 1'b0);
    runScenario(1, 19'h00020, 1, 19'h00024, 1'b0);

    // stray beats in IDLE and a stray ack must do nothing
    bus.memDataValid = 1'b1; bus.memData = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus.memDataValid = 1'b0; bus.memAck = 1'b1;
    tick();
    bus.memAck = 1'b0;
    runScenario(0, 19'h0, 1, 19'h12345, 1'b1);

    // held miss: the same base is re-requested only after the holdoff window
    aA = 19'h03A61;
    predict(1, aA, 0, 0);
    predict(1, aA, 0, 0);
    setMiss(1, aA, 0, 0);
    serveBurst(planBase[0], planCov[0], -1, 1'b1, 1'b0);
    n = 0;
    while (!bus.memReq && n < 20) begin n++; tick(); end
    chk("holdoff_gap", 64'(n), 64'(HO + 1));
    serveBurst(planBase[0], planCov[0], -1, 1'b0, 1'b0);
    repeat (HO + 2) tick();

    // reset after two beats, then late beats, then a fresh miss
    aA = 19'($urandom_range(256, 19'h7FFFF));
    predict(1, aA, 0, 0);
    setMiss(1, aA, 0, 0);
    serveBurst(planBase[0], planCov[0], 2, 1'b0, 1'b0);
    bus.memDataValid = 1'b1; bus.memData = {$urandom, $urandom};
    repeat (2) tick();
    bus.memDataValid = 1'b0;
    runScenario(1, 19'h00125, 0, 19'h0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      mA = 1'($urandom_range(0, 1));
      mB = mA ? 1'($urandom_range(0, 1)) : 1'b1;
      aA = 19'($urandom_range(0, 19'h7FFFF));
      aB = 19'($urandom_range(0, 19'h7FFFF));
      if ($urandom_range(0, 3) == 0) aB = (aA & ~19'(4 * BL - 1)) | 19'($urandom_range(0, 4 * BL - 1));
      runScenario(mA, aA, mB, aB, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("pending_req", 64'(expReqQ.size()), 0);
    chk("pending_write", 64'(expWrQ.size()), 0);
    chk("pending_served", 64'(expSrvQ.size()), 0);
    chk("final_busy", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
